enc_8x3: RTL and testbench



---
 rtl/enc_8x3_pkg.sv | 23 ++
 rtl/enc_8x3_prio_enc8.sv | 28 ++
 rtl/enc_8x3.sv | 85 ++++++++
 tb/tb_enc_8x3.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_8x3_pkg.sv
// Shared types and helpers for the 8-to-3 edge-capture priority encoder.
// Imported by the encoder top level and its priority sub-module.
package enc_8x3_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam logic [N_REQ-1:0] Y_IDLE = 8'hFF;

    typedef enum logic {
        IDLE,
        HOLD
    } enc_state_t;

    function automatic logic [N_REQ-1:0] onehot3(
        input logic [IDX_W-1:0] idx
    );
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/enc_8x3_prio_enc8.sv
// Combinational 8-input priority encoder.
// The priority direction is selectable at the input.
module prio_enc8
    import enc_8x3_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_lsb_first,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // The last matching iteration wins, so the scan runs toward the winner.
    always_comb begin
        o_idx = '0;
        if (i_lsb_first) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (i_req[i]) o_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (i_req[i]) o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/enc_8x3.sv
// Registered 8-to-3 priority encoder that captures falling edges on
// active-low request lines and hands out codes over valid/ready.
module enc_8x3
    import enc_8x3_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] y,
    input  logic             en,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             valid,
    input  logic             ready,
    output logic [N_REQ-1:0] pending,
    output logic             overrun
);

    enc_state_t       r_state;
    logic [N_REQ-1:0] r_y_q;
    logic [N_REQ-1:0] r_pending;
    logic [IDX_W-1:0] r_code;
    logic             r_valid;
    logic             r_overrun;

    logic [N_REQ-1:0] w_fe;
    logic [N_REQ-1:0] w_clr;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic             w_accept;

    prio_enc8 u_prio (
        .i_req       (r_pending),
        .i_lsb_first (LSB_FIRST),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    assign w_fe     = r_y_q & ~y;
    assign w_accept = (r_state == HOLD) & r_valid & ready;
    assign w_clr    = w_accept ? onehot3(r_code) : '0;

    // A fresh edge ORed in after the clear lets set win on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_y_q     <= Y_IDLE;
            r_pending <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_y_q     <= y;
            r_pending <= (r_pending & ~w_clr) | w_fe;
            r_overrun <= |(w_fe & r_pending & ~w_clr);
            case (r_state)
                IDLE: begin
                    if (!en && w_any) begin
                        r_code  <= w_idx;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c} = r_code;
    assign valid     = r_valid;
    assign pending   = r_pending;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_enc_8x3.sv
// Self-checking bench for enc_8x3: directed scenarios plus random
// traffic compared against a behavioural model for both priority orders.
module tb_enc_8x3;

    logic       clk;
    logic       rst_n;
    logic [7:0] y;
    logic       en;
    logic       ready;

    logic       a0, b0, c0, valid0, ovr0;
    logic [7:0] pend0;
    logic       a1, b1, c1, valid1, ovr1;
    logic [7:0] pend1;
    logic [2:0] code0, code1;

    int n_chk;
    int n_fail;

    logic [7:0] m_yq;
    logic [7:0] m_pend [2];
    logic       m_valid[2];
    logic [2:0] m_code [2];
    logic       m_ovr  [2];

    assign code0 = {a0, b0, c0};
    assign code1 = {a1, b1, c1};

    enc_8x3 #(.LSB_FIRST(1'b0)) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .y       (y),
        .en      (en),
        .a       (a0),
        .b       (b0),
        .c       (c0),
        .valid   (valid0),
        .ready   (ready),
        .pending (pend0),
        .overrun (ovr0)
    );

    enc_8x3 #(.LSB_FIRST(1'b1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .y       (y),
        .en      (en),
        .a       (a1),
        .b       (b1),
        .c       (c1),
        .valid   (valid1),
        .ready   (ready),
        .pending (pend1),
        .overrun (ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest set bit via log2, lowest set bit via two's-complement isolation.
    function automatic logic [2:0] best(input logic [7:0] p, input int lsb);
        int u;
        int low;
        u   = int'(p);
        low = u & (-u);
        if (lsb != 0) return 3'($clog2(low + 1) - 1);
        return 3'($clog2(u + 1) - 1);
    endfunction

    function automatic logic [7:0] acc_mask(
        input logic v, input logic r, input logic [2:0] code
    );
        if (v && r) return 8'd1 << code;
        return 8'h00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_yq <= 8'hFF;
            for (int k = 0; k < 2; k++) begin
                m_pend[k]  <= 8'h00;
                m_valid[k] <= 1'b0;
                m_code[k]  <= 3'd0;
                m_ovr[k]   <= 1'b0;
            end
        end else begin
            m_yq <= y;
            for (int k = 0; k < 2; k++) begin
                m_ovr[k] <= ((m_yq & ~y) & m_pend[k]
                    & ~acc_mask(m_valid[k], ready, m_code[k])) != 8'h00;
                m_pend[k] <= (m_pend[k]
                    & ~acc_mask(m_valid[k], ready, m_code[k])) | (m_yq & ~y);
                if (m_valid[k]) begin
                    if (ready) m_valid[k] <= 1'b0;
                end else if (!en && m_pend[k] != 8'h00) begin
                    m_valid[k] <= 1'b1;
                    m_code[k]  <= best(m_pend[k], k);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        y     = 8'hFF;
        en    = 1'b0;
        ready = 1'b0;
        #12;
        n_chk++;
        if ({valid0, pend0, ovr0, code0} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_dut0 got v=%b p=%h o=%b c=%b want all 0",
                valid0, pend0, ovr0, code0);
        end
        n_chk++;
        if ({valid1, pend1, ovr1, code1} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_dut1 got v=%b p=%h o=%b c=%b want all 0",
                valid1, pend1, ovr1, code1);
        end
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_single();
        y = 8'hFB;
        step();
        n_chk++;
        if (pend0 !== 8'h04 || valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pend got p=%h v=%b want 04 0", pend0, valid0);
        end
        y = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (valid0 !== 1'b1 || code0 !== 3'b010) begin
                n_fail++;
                $display("FAIL single_hold%0d got v=%b c=%b want 1 010",
                    i, valid0, code0);
            end
        end
        ready = 1'b1;
        step();
        n_chk++;
        if (valid0 !== 1'b0 || pend0 !== 8'h00) begin
            n_fail++;
            $display("FAIL single_accept got v=%b p=%h want 0 00",
                valid0, pend0);
        end
        ready = 1'b0;
        step();
    endtask

    task automatic test_priority();
        logic [2:0] exp0 [3];
        logic [2:0] exp1 [3];
        exp0[0] = 3'd7; exp0[1] = 3'd4; exp0[2] = 3'd0;
        exp1[0] = 3'd0; exp1[1] = 3'd4; exp1[2] = 3'd7;
        ready = 1'b1;
        y = 8'h6E;
        step();
        n_chk++;
        if (pend0 !== 8'h91 || pend1 !== 8'h91) begin
            n_fail++;
            $display("FAIL prio_pend got %h/%h want 91", pend0, pend1);
        end
        y = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (valid0 !== 1'b1 || code0 !== exp0[i]) begin
                n_fail++;
                $display("FAIL prio_msb%0d got v=%b c=%b want 1 %b",
                    i, valid0, code0, exp0[i]);
            end
            n_chk++;
            if (valid1 !== 1'b1 || code1 !== exp1[i]) begin
                n_fail++;
                $display("FAIL prio_lsb%0d got v=%b c=%b want 1 %b",
                    i, valid1, code1, exp1[i]);
            end
            step();
            n_chk++;
            if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
                n_fail++;
                $display("FAIL prio_gap%0d got v=%b/%b want 0",
                    i, valid0, valid1);
            end
        end
        n_chk++;
        if (pend0 !== 8'h00 || pend1 !== 8'h00) begin
            n_fail++;
            $display("FAIL prio_drain got %h/%h want 00", pend0, pend1);
        end
        ready = 1'b0;
    endtask

    task automatic test_overrun();
        y = 8'hF7;
        step();
        y = 8'hFF;
        step();
        n_chk++;
        if (valid0 !== 1'b1 || code0 !== 3'b011 || ovr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_grant got v=%b c=%b o=%b want 1 011 0",
                valid0, code0, ovr0);
        end
        y = 8'hF7;
        step();
        n_chk++;
        if (ovr0 !== 1'b1 || pend0 !== 8'h08) begin
            n_fail++;
            $display("FAIL ovr_pulse got o=%b p=%h want 1 08", ovr0, pend0);
        end
        y = 8'hFF;
        step();
        n_chk++;
        if (ovr0 !== 1'b0 || pend0 !== 8'h08) begin
            n_fail++;
            $display("FAIL ovr_drop got o=%b p=%h want 0 08", ovr0, pend0);
        end
        y = 8'hF7;
        ready = 1'b1;
        step();
        n_chk++;
        if (pend0 !== 8'h08 || valid0 !== 1'b0 || ovr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL setwins got p=%h v=%b o=%b want 08 0 0",
                pend0, valid0, ovr0);
        end
        y = 8'hFF;
        ready = 1'b0;
        step();
        n_chk++;
        if (valid0 !== 1'b1 || code0 !== 3'b011) begin
            n_fail++;
            $display("FAIL setwins_regrant got v=%b c=%b want 1 011",
                valid0, code0);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_chk++;
        if (pend0 !== 8'h00 || valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clean got p=%h v=%b want 00 0", pend0, valid0);
        end
        step();
    endtask

    task automatic test_enable();
        en = 1'b1;
        y = 8'hDD;
        step();
        y = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (pend0 !== 8'h22 || valid0 !== 1'b0) begin
                n_fail++;
                $display("FAIL en_gate%0d got p=%h v=%b want 22 0",
                    i, pend0, valid0);
            end
            step();
        end
        en = 1'b0;
        step();
        n_chk++;
        if (valid0 !== 1'b1 || code0 !== 3'b101) begin
            n_fail++;
            $display("FAIL en_grant got v=%b c=%b want 1 101", valid0, code0);
        end
        en = 1'b1;
        step();
        n_chk++;
        if (valid0 !== 1'b1 || code0 !== 3'b101) begin
            n_fail++;
            $display("FAIL en_hold got v=%b c=%b want 1 101", valid0, code0);
        end
        ready = 1'b1;
        step();
        n_chk++;
        if (valid0 !== 1'b0 || pend0 !== 8'h02) begin
            n_fail++;
            $display("FAIL en_complete got v=%b p=%h want 0 02",
                valid0, pend0);
        end
        ready = 1'b0;
        step();
        n_chk++;
        if (valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL en_block got v=%b want 0", valid0);
        end
        en = 1'b0;
        step();
        n_chk++;
        if (valid0 !== 1'b1 || code0 !== 3'b001) begin
            n_fail++;
            $display("FAIL en_resume got v=%b c=%b want 1 001", valid0, code0);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        y = 8'h7E;
        step();
        n_chk++;
        if (pend0 !== 8'h81) begin
            n_fail++;
            $display("FAIL mid_pend got %h want 81", pend0);
        end
        y = 8'h7F;
        step();
        n_chk++;
        if (valid0 !== 1'b1 || code0 !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_hold got v=%b c=%b want 1 111", valid0, code0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({valid0, pend0, ovr0, code0} !== 13'h0) begin
            n_fail++;
            $display("FAIL mid_async got v=%b p=%h o=%b c=%b want all 0",
                valid0, pend0, ovr0, code0);
        end
        #2;
        rst_n = 1'b1;
        step();
        n_chk++;
        if (pend0 !== 8'h80 || valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release got p=%h v=%b want 80 0",
                pend0, valid0);
        end
        step();
        n_chk++;
        if (valid0 !== 1'b1 || code0 !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_regrant got v=%b c=%b want 1 111",
                valid0, code0);
        end
        ready = 1'b1;
        y = 8'hFF;
        step();
        ready = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            y     = ~(8'($urandom) & 8'($urandom));
            en    = ($urandom_range(0, 3) == 0);
            ready = 1'($urandom_range(0, 1));
            step();
            n_chk++;
            if ({valid0, pend0, ovr0, code0} !==
                {m_valid[0], m_pend[0], m_ovr[0], m_code[0]}) begin
                n_fail++;
                $display("FAIL rand_dut0 cyc%0d got %b/%h/%b/%b want %b/%h/%b/%b",
                    i, valid0, pend0, ovr0, code0,
                    m_valid[0], m_pend[0], m_ovr[0], m_code[0]);
            end
            n_chk++;
            if ({valid1, pend1, ovr1, code1} !==
                {m_valid[1], m_pend[1], m_ovr[1], m_code[1]}) begin
                n_fail++;
                $display("FAIL rand_dut1 cyc%0d got %b/%h/%b/%b want %b/%h/%b/%b",
                    i, valid1, pend1, ovr1, code1,
                    m_valid[1], m_pend[1], m_ovr[1], m_code[1]);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_priority();
        test_overrun();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end

endmodule
